// File: rtl/noise_pkg.sv
// Shared constants and word layout for the noise generator core.
// Word: [23]=kind (1 seed / 0 freq), [22]=IMM for freq words.
package noise_pkg;

    localparam int WORD_W   = 24;
    localparam int KIND_BIT = 23;
    localparam int IMM_BIT  = 22;
    localparam int FREQ_FLD = 17;
    localparam int SEED_FLD = 23;

    localparam int FREQ_W   = 17;
    localparam int LFSR_W   = 23;
    localparam int DEF_DIV  = 13000;
    localparam int DEF_SEED = 111111;
    localparam int MIN_DIV  = 2;

    typedef enum logic {
        WK_FREQ = 1'b0,
        WK_SEED = 1'b1
    } word_kind_e;

    typedef struct packed {
        word_kind_e  kind;
        logic        imm;
        logic [21:0] body;
    } cfg_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to first valid at or after rr.
// Ports: sys_clk, sys_rst, valid[N], advance (accept pulse), grant[N].
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic [N-1:0] valid,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    logic [PW-1:0] rr;
    logic [PW-1:0] idx;
    logic [PW-1:0] gidx;
    logic          found;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
        return (i == LAST) ? '0 : i + PW'(1);
    endfunction

    // Walk N positions starting at rr, wrapping; first valid wins.
    always_comb begin
        grant = '0;
        gidx  = rr;
        found = 1'b0;
        idx   = rr;
        for (int k = 0; k < N; k++) begin
            if (!found && valid[idx]) begin
                found      = 1'b1;
                gidx       = idx;
                grant[idx] = 1'b1;
            end
            idx = nxt(idx);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rr <= '0;
        end else if (advance && found) begin
            rr <= nxt(gidx);
        end
    end

endmodule

// File: rtl/noise_cfg_sched.sv
// Config scheduler: arbitrates requester words, holds one pending update
// per kind and applies divider/seed on period_tick (IMM freq bypasses).
// Ports: sys_clk, sys_rst, req_valid/req_word/req_ready, period_tick,
// freq_div, seed, seed_load, freq_pend, seed_pend, overwrite_cnt.
module noise_cfg_sched #(
    parameter int N_REQ    = 2,
    parameter int FREQ_W   = noise_pkg::FREQ_W,
    parameter int LFSR_W   = noise_pkg::LFSR_W,
    parameter int DEF_DIV  = noise_pkg::DEF_DIV,
    parameter int DEF_SEED = noise_pkg::DEF_SEED,
    parameter int MIN_DIV  = noise_pkg::MIN_DIV
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*24-1:0] req_word,
    output logic [N_REQ-1:0]    req_ready,
    input  logic                period_tick,
    output logic [FREQ_W-1:0]   freq_div,
    output logic [LFSR_W-1:0]   seed,
    output logic                seed_load,
    output logic                freq_pend,
    output logic                seed_pend,
    output logic [7:0]          overwrite_cnt
);

    import noise_pkg::*;

    logic [N_REQ-1:0]    grant;
    logic                accept;
    cfg_word_t           word;
    logic                is_seed;
    logic                is_imm;
    logic [SEED_FLD-1:0] seed_raw;
    logic [FREQ_W-1:0]   freq_raw;
    logic [LFSR_W-1:0]   seed_val;
    logic [FREQ_W-1:0]   freq_val;
    logic [FREQ_W-1:0]   freq_slot;
    logic [LFSR_W-1:0]   seed_slot;
    logic                apply_f;
    logic                apply_s;
    logic                bump;

    rr_arbiter #(
        .N(N_REQ)
    ) u_arb (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .valid   (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                word = cfg_word_t'(req_word[i*WORD_W +: WORD_W]);
            end
        end
    end

    assign is_seed  = (word.kind == WK_SEED);
    assign is_imm   = word.imm;
    assign seed_raw = {word.imm, word.body};
    assign freq_raw = FREQ_W'(word.body[FREQ_FLD-1:0]);

    // Zero seed would lock the LFSR; tiny dividers are clamped up.
    always_comb begin
        if (seed_raw == '0) begin
            seed_val = LFSR_W'(DEF_SEED);
        end else begin
            seed_val = LFSR_W'(seed_raw);
        end
        if (freq_raw < FREQ_W'(MIN_DIV)) begin
            freq_val = FREQ_W'(MIN_DIV);
        end else begin
            freq_val = freq_raw;
        end
    end

    // Only flags set before this cycle are applied by this tick.
    assign apply_f = period_tick & freq_pend;
    assign apply_s = period_tick & seed_pend;

    // A slot drained by this tick is not an overwrite.
    assign bump = accept & (is_seed ? (seed_pend & ~apply_s)
                                    : (~is_imm & freq_pend & ~apply_f));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            freq_div      <= FREQ_W'(DEF_DIV);
            seed          <= LFSR_W'(DEF_SEED);
            seed_load     <= 1'b0;
            freq_pend     <= 1'b0;
            seed_pend     <= 1'b0;
            freq_slot     <= FREQ_W'(DEF_DIV);
            seed_slot     <= LFSR_W'(DEF_SEED);
            overwrite_cnt <= 8'd0;
        end else begin
            seed_load <= apply_s;
            if (apply_s) begin
                seed      <= seed_slot;
                seed_pend <= 1'b0;
            end
            if (apply_f) begin
                freq_div  <= freq_slot;
                freq_pend <= 1'b0;
            end
            if (accept && is_seed) begin
                seed_slot <= seed_val;
                seed_pend <= 1'b1;
            end
            if (accept && !is_seed) begin
                if (is_imm) begin
                    freq_div  <= freq_val;
                    freq_pend <= 1'b0;
                end else begin
                    freq_slot <= freq_val;
                    freq_pend <= 1'b1;
                end
            end
            if (bump && overwrite_cnt != 8'hFF) begin
                overwrite_cnt <= overwrite_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_noise_cfg_sched.sv
// Bench for noise_cfg_sched: directed vector table, saturation and
// reset sequences, then random traffic against a queue-based model.
module tb_noise_cfg_sched;

    localparam int N = 2;

    logic            sys_clk = 1'b0;
    logic            sys_rst;
    logic [N-1:0]    req_valid;
    logic [N*24-1:0] req_word;
    logic [N-1:0]    req_ready;
    logic            period_tick;
    logic [16:0]     freq_div;
    logic [22:0]     seed;
    logic            seed_load;
    logic            freq_pend;
    logic            seed_pend;
    logic [7:0]      overwrite_cnt;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    noise_cfg_sched #(
        .N_REQ(N)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .req_valid     (req_valid),
        .req_word      (req_word),
        .req_ready     (req_ready),
        .period_tick   (period_tick),
        .freq_div      (freq_div),
        .seed          (seed),
        .seed_load     (seed_load),
        .freq_pend     (freq_pend),
        .seed_pend     (seed_pend),
        .overwrite_cnt (overwrite_cnt)
    );

    typedef struct {
        logic [1:0]  v;
        logic [23:0] w0;
        logic [23:0] w1;
        logic        t;
        logic [1:0]  rdy;
        int          f;
        int          s;
        bit          l;
        bit          fp;
        bit          sp;
        int          c;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic [1:0] v, logic [23:0] w0,
                                logic [23:0] w1, logic t, logic [1:0] rdy,
                                int f, int s, bit l, bit fp, bit sp, int c);
        vec_t e;
        e.v = v; e.w0 = w0; e.w1 = w1; e.t = t; e.rdy = rdy;
        e.f = f; e.s = s; e.l = l; e.fp = fp; e.sp = sp; e.c = c;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int f, input int s,
                               input bit l, input bit fp, input bit sp,
                               input int c);
        chk({tag, " freq_div"}, 32'(freq_div), f);
        chk({tag, " seed"}, 32'(seed), s);
        chk({tag, " seed_load"}, 32'(seed_load), 32'(l));
        chk({tag, " freq_pend"}, 32'(freq_pend), 32'(fp));
        chk({tag, " seed_pend"}, 32'(seed_pend), 32'(sp));
        chk({tag, " overwrite_cnt"}, 32'(overwrite_cnt), c);
    endtask

    task automatic drive(input logic [1:0] v, input logic [23:0] w0,
                         input logic [23:0] w1, input logic t);
        req_valid   = v;
        req_word    = {w1, w0};
        period_tick = t;
    endtask

    // Reference model: pending updates as queues of depth <= 1.
    int m_rr, m_freq, m_seed, m_cnt;
    bit m_load;
    int fq[$];
    int sq[$];

    function automatic void m_reset();
        m_rr = 0; m_freq = 13000; m_seed = 111111; m_cnt = 0; m_load = 0;
        fq.delete();
        sq.delete();
    endfunction

    function automatic int m_grant(logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic void m_step(logic [N-1:0] v, logic [N*24-1:0] wds,
                                   logic t);
        int g;
        int val;
        bit ap_f;
        bit ap_s;
        logic [23:0] w;
        g = m_grant(v);
        ap_f = t && fq.size() > 0;
        ap_s = t && sq.size() > 0;
        m_load = 0;
        if (ap_s) begin
            m_seed = sq.pop_front();
            m_load = 1;
        end
        if (ap_f) m_freq = fq.pop_front();
        if (g >= 0) begin
            w = wds[g*24 +: 24];
            if (w[23]) begin
                val = (w[22:0] == 0) ? 111111 : int'(w[22:0]);
                if (sq.size() > 0) begin
                    if (m_cnt < 255) m_cnt++;
                    sq.delete();
                end
                sq.push_back(val);
            end else begin
                val = int'(w[16:0]);
                if (val < 2) val = 2;
                if (w[22]) begin
                    m_freq = val;
                    fq.delete();
                end else begin
                    if (fq.size() > 0) begin
                        if (m_cnt < 255) m_cnt++;
                        fq.delete();
                    end
                    fq.push_back(val);
                end
            end
            m_rr = (g + 1) % N;
        end
    endfunction

    function automatic logic [23:0] rnd_word();
        logic [23:0] w;
        w = 24'($urandom);
        case ($urandom_range(0, 3))
            0: w[22:0] = '0;
            1: w[16:0] = 17'($urandom_range(0, 3));
            default: ;
        endcase
        if (!w[23]) w[22] = ($urandom_range(0, 7) == 0);
        return w;
    endfunction

    initial begin
        int g;
        logic [1:0] er;
        logic [1:0] rv;
        logic [23:0] rw0;
        logic [23:0] rw1;
        logic rt;

        add(2'b01, 24'h000400, 24'h0, 1'b0, 2'b01, 13000, 111111, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++)
            add(2'b00, 24'h0, 24'h0, 1'b0, 2'b00, 13000, 111111, 0, 1, 0, 0);
        add(2'b00, 24'h0, 24'h0, 1'b1, 2'b00, 1024, 111111, 0, 0, 0, 0);
        add(2'b10, 24'h0, 24'h800000, 1'b0, 2'b10, 1024, 111111, 0, 0, 1, 0);
        add(2'b00, 24'h0, 24'h0, 1'b1, 2'b00, 1024, 111111, 1, 0, 0, 0);
        add(2'b00, 24'h0, 24'h0, 1'b0, 2'b00, 1024, 111111, 0, 0, 0, 0);
        add(2'b01, 24'h0001F4, 24'h0, 1'b0, 2'b01, 1024, 111111, 0, 1, 0, 0);
        add(2'b10, 24'h0, 24'h0002BC, 1'b0, 2'b10, 1024, 111111, 0, 1, 0, 1);
        add(2'b00, 24'h0, 24'h0, 1'b1, 2'b00, 700, 111111, 0, 0, 0, 1);
        add(2'b01, 24'h000001, 24'h0, 1'b0, 2'b01, 700, 111111, 0, 1, 0, 1);
        add(2'b00, 24'h0, 24'h0, 1'b1, 2'b00, 2, 111111, 0, 0, 0, 1);
        add(2'b10, 24'h0, 24'h801234, 1'b1, 2'b10, 2, 111111, 0, 0, 1, 1);
        add(2'b11, 24'h000190, 24'h800005, 1'b0, 2'b01, 2, 111111, 0, 1, 1, 1);
        add(2'b11, 24'h000190, 24'h800005, 1'b0, 2'b10, 2, 111111, 0, 1, 1, 2);
        add(2'b11, 24'h000190, 24'h800005, 1'b0, 2'b01, 2, 111111, 0, 1, 1, 3);
        add(2'b11, 24'h000190, 24'h800005, 1'b0, 2'b10, 2, 111111, 0, 1, 1, 4);
        add(2'b00, 24'h0, 24'h0, 1'b1, 2'b00, 400, 5, 1, 0, 0, 4);
        add(2'b01, 24'h0001F4, 24'h0, 1'b0, 2'b01, 400, 5, 0, 1, 0, 4);
        add(2'b01, 24'h400064, 24'h0, 1'b0, 2'b01, 100, 5, 0, 0, 0, 4);
        add(2'b00, 24'h0, 24'h0, 1'b1, 2'b00, 100, 5, 0, 0, 0, 4);
        add(2'b01, 24'h800007, 24'h0, 1'b0, 2'b01, 100, 5, 0, 0, 1, 4);
        add(2'b10, 24'h0, 24'h4000FA, 1'b1, 2'b10, 250, 7, 1, 0, 0, 4);
        add(2'b00, 24'h0, 24'h0, 1'b0, 2'b00, 250, 7, 0, 0, 0, 4);

        sys_rst = 1'b1;
        drive(2'b00, 24'h0, 24'h0, 1'b0);
        repeat (2) @(posedge sys_clk);
        #1;
        check_state("reset", 13000, 111111, 0, 0, 0, 0);
        sys_rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].w0, tbl[i].w1, tbl[i].t);
            #2;
            chk($sformatf("row%0d req_ready", i), 32'(req_ready),
                32'(tbl[i].rdy));
            @(posedge sys_clk);
            #1;
            check_state($sformatf("row%0d", i), tbl[i].f, tbl[i].s,
                        tbl[i].l, tbl[i].fp, tbl[i].sp, tbl[i].c);
        end

        // Asynchronous reset between edges.
        drive(2'b00, 24'h0, 24'h0, 1'b0);
        sys_rst = 1'b1;
        #2;
        check_state("async_rst", 13000, 111111, 0, 0, 0, 0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        // Overwrite counter saturation.
        drive(2'b01, 24'h000010, 24'h0, 1'b0);
        repeat (255) @(posedge sys_clk);
        #1;
        chk("sat 254", 32'(overwrite_cnt), 254);
        @(posedge sys_clk);
        #1;
        chk("sat 255", 32'(overwrite_cnt), 255);
        repeat (5) @(posedge sys_clk);
        #1;
        chk("sat hold", 32'(overwrite_cnt), 255);
        drive(2'b00, 24'h0, 24'h0, 1'b1);
        @(posedge sys_clk);
        #1;
        chk("sat apply freq", 32'(freq_div), 16);

        // Random traffic against the model.
        drive(2'b00, 24'h0, 24'h0, 1'b0);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                drive(2'(($urandom)), rnd_word(), rnd_word(), 1'b0);
                sys_rst = 1'b1;
                #2;
                check_state("mid_rst", 13000, 111111, 0, 0, 0, 0);
                m_reset();
                @(posedge sys_clk);
                #1;
                sys_rst = 1'b0;
            end
            rv  = 2'($urandom);
            rw0 = rnd_word();
            rw1 = rnd_word();
            rt  = ($urandom_range(0, 5) == 0);
            drive(rv, rw0, rw1, rt);
            #2;
            g  = m_grant(rv);
            er = (g < 0) ? 2'b00 : 2'(1 << g);
            chk($sformatf("rnd%0d req_ready", n), 32'(req_ready), 32'(er));
            @(posedge sys_clk);
            m_step(rv, {rw1, rw0}, rt);
            #1;
            check_state($sformatf("rnd%0d", n), m_freq, m_seed, m_load,
                        fq.size() > 0, sq.size() > 0, m_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noise_cfg_sched.md
# noise_cfg_sched

Configuration scheduler for the noise generator core. Collects 24-bit configuration words from several requesters (SPI receiver, envelope/sweep sequencers) and arbitrates them round-robin. Holds one pending update per register kind and applies it to the core's frequency divider and LFSR seed only on a period boundary, so the divider counter never glitches mid-period. It sits between the command sources and the noise datapath and owns the core's `freq_div` and seed registers.

## Interface
- `N_REQ`, default 2: number of requesters, range 1..8.
- `FREQ_W`, default 17: divider width.
- `LFSR_W`, default 23: LFSR/seed width.
- `DEF_DIV`, default 13000: reset divider value.
- `DEF_SEED`, default 111111: reset seed, also the substitute for a zero seed.
- `MIN_DIV`, default 2: smallest legal divider; lower values are clamped up to it.

Ports:
- `sys_clk` in 1: single clock; all logic is on the rising edge.
- `sys_rst` in 1: asynchronous, active-high reset.
- `req_valid` in N_REQ: requester i presents a word.
- `req_word` in N_REQ*24: word of requester i, at bits [24i+23:24i].
- `req_ready` out N_REQ: grant, combinational; a word is accepted when valid && ready.
- `period_tick` in 1: one-cycle pulse from the core when its divider counter wraps.
- `freq_div` out FREQ_W: divider applied to the core. Reset value DEF_DIV.
- `seed` out LFSR_W: seed value. Reset value DEF_SEED.
- `seed_load` out 1: one-cycle pulse; the core loads `seed` into its LFSR. Reset value 0.
- `freq_pend`, `seed_pend` out 1 each: a pending update of that kind exists. Reset value 0.
- `overwrite_cnt` out 8: count of pending words replaced before they were applied. Saturates at 255. Reset value 0.

## Operation
Word format:
- bit 23 = 1: seed word, seed value in [22:0].
- bit 23 = 0: frequency word, divider in [16:0]. Bit 22 = IMM. Bits [21:17] are ignored.

Arbitration:
- At most one grant per cycle.
- Round-robin pointer `rr`, reset to 0. Grant goes to the first valid index at or after `rr`, taken modulo N_REQ.
- After an accept, `rr` moves to the granted index + 1, wrapping.
- `req_ready` is low for every requester that is not granted.

Accepted word handling:
- Seed word: a value of 0 is replaced by DEF_SEED. The result goes into the seed pending slot and `seed_pend` is set.
- Frequency word: the value is clamped to MIN_DIV. The result goes into the frequency pending slot and `freq_pend` is set.
- Frequency word with IMM=1: the pending slot is bypassed and the value is applied at the next edge, regardless of `period_tick`. Any existing frequency pending value is discarded and `freq_pend` is cleared. This does not count as an overwrite.
- Accept into a slot that is already pending: last write wins, and `overwrite_cnt` increments.

Application:
- On a cycle where `period_tick`=1, every slot whose pending flag was set before that cycle is applied:
  - `freq_div` and/or `seed` are updated.
  - `seed_load` pulses if a seed was applied.
  - The corresponding pending flags are cleared.
- A word accepted on the same cycle as `period_tick` is not applied by that tick. It stays pending until the next tick.

Reset asserted mid-operation returns every register to its reset value immediately: pending words are lost and `rr` returns to 0.

## Timing
- Accept at edge k: the pending flag is visible after edge k.
- `period_tick` high in cycle m with a slot already pending: the new `freq_div`/`seed` and `seed_load`=1 are visible after edge m. `seed_load` drops after edge m+1.
- IMM frequency accept at edge k: `freq_div` is updated after edge k, one cycle of latency.
- IMM accept and `period_tick` in the same cycle: IMM wins for `freq_div`. A pending seed is still applied.
- Throughput is one word per cycle in aggregate.
- No combinational path from `period_tick` to any output.

## Structure
- Package `noise_pkg`: word bit positions (KIND=23, IMM=22), FREQ_W, LFSR_W, DEF_DIV, DEF_SEED, MIN_DIV. The noise core uses the same package.
- Sub-module `rr_arbiter` (parameter N): inputs `valid` and the `advance` pulse, outputs a one-hot `grant`, holds the `rr` pointer.
- The scheduler top holds the slots, the clamp/substitute logic, the apply logic and the counter.

## Test plan
1. Reset → `freq_div`=13000, `seed`=111111, `seed_load`=0, both pending flags 0, `overwrite_cnt`=0. Async assert with no clock edge must take effect.
2. Requester 0 writes 0x000400, then a tick 10 cycles later → `freq_div` stays 13000 until the tick, then becomes 1024. `freq_pend` is high in between.
3. Both requesters valid for 4 cycles → grants alternate 0,1,0,1 and each `req_ready` is one-hot.
4. Two frequency words 500 then 700 before a tick → `freq_div`=700 after the tick and `overwrite_cnt`=1. A word 0x000001 is clamped, giving 2.
5. Seed word 0x800000 followed by a tick → `seed`=111111 and `seed_load` is high for exactly one cycle.
6. IMM word 0x400064 while 500 is pending → `freq_div`=100 one edge later and `freq_pend` is cleared. A later tick leaves 100 unchanged. Asserting `sys_rst` mid-stream restores the defaults.
